axis_sync_fifo: RTL and testbench
=================================

# axis_sync_fifo

Single-clock AXI-Stream data FIFO; the parametrised successor of the dual-clock `fifo_top` for paths that need no clock crossing. Buffers `s_axis` beats (data, keep, last) and replays them on `m_axis` in order. Adds optional packet mode, occupancy count and programmable almost-full/almost-empty flags. Sits between stream producers and consumers inside the AXIS data FIFO IP.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: entries. Power of two, ≥ 4.
- `FIFO_WIDTH`, 32: tdata bits. Multiple of 8.
- `PACKET_MODE`, 0: 1 means m_axis presents data only once a complete packet is stored.
- `ALMOST_FULL_THRESH`, FIFO_DEPTH-2: `almost_full` asserts when count ≥ this value.
- `ALMOST_EMPTY_THRESH`, 2: `almost_empty` asserts when count ≤ this value.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in FIFO_WIDTH; `s_axis_tkeep` in FIFO_WIDTH/8; `s_axis_tlast` in 1; `s_axis_tvalid` in 1; `s_axis_tready` out 1.
- `m_axis_tdata` out FIFO_WIDTH; `m_axis_tkeep` out FIFO_WIDTH/8; `m_axis_tlast` out 1; `m_axis_tvalid` out 1; `m_axis_tready` in 1.
- `data_count` out $clog2(FIFO_DEPTH)+1: entries stored.
- `almost_full` out 1; `almost_empty` out 1.

## Operation
- Push when `s_axis_tvalid && s_axis_tready`. Pop when `m_axis_tvalid && m_axis_tready`.
- Write/read pointers are $clog2(FIFO_DEPTH)+1 bits wide. Index uses the low bits. Full means the MSBs differ and the rest are equal; empty means the pointers are equal. Wrap is natural modulo 2·FIFO_DEPTH.
- `s_axis_tready = !full`. There is no push-through-when-full bypass.
- `data_count` = wr_ptr − rd_ptr, computed modulo 2·FIFO_DEPTH. Push and pop in the same cycle leave it unchanged.
- Storage is first-word-fall-through. The m_axis payload equals the memory at the read index. The payload is stable while `tvalid && !tready`.
- Packet mode off: `m_axis_tvalid = !empty`.
- Packet mode on:
  - `pkt_count` increments on a push with tlast and decrements on a pop with tlast. Both in one cycle leave it unchanged.
  - `m_axis_tvalid = !empty && (pkt_count != 0 || full)`.
  - The `full` term is the deadlock escape for packets longer than FIFO_DEPTH. Once a packet starts draining, `tvalid` stays high until its tlast beat pops or the FIFO empties.
- The flags are derived combinationally from the registered count.
- `rst` clears the pointers, `pkt_count` and the draining flag. Reset during an in-flight packet discards all contents. Inputs are ignored in the reset cycle.

## Timing
- Reset values:
  - `s_axis_tready` = 1
  - `m_axis_tvalid` = 0
  - `data_count` = 0
  - `almost_full` = 0
  - `almost_empty` = 1
  - `m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast` = don't-care (mem is not reset)
- Latency: a beat pushed at edge N into an empty FIFO is valid on m_axis after edge N (packet mode off). In packet mode it is valid after the edge that pushes its packet's tlast.
- `s_axis_tready` drops the cycle after the push that fills the FIFO. It rises the cycle after the first pop from full.
- When full and both sides are active, only the pop occurs. When empty and both sides are active, only the push occurs.

## Structure
- Package `axis_fifo_pkg`:
  - `ptr_w(depth)` function.
  - Default parameter constants.
  - Elaboration-time parameter checks: power-of-two depth, byte-multiple width, thresholds within 0..FIFO_DEPTH.
- Sub-module `axis_fifo_mem`:
  - Simple dual-port array, width FIFO_WIDTH + FIFO_WIDTH/8 + 1.
  - Synchronous write, asynchronous read.
- Top level holds the pointers, count, packet logic and flags.

## Test plan
All scenarios use FIFO_DEPTH=16 unless noted.
- **Fill then drain.** Reset; push 16 beats 0x0..0xF with m_axis_tready=0 → `s_axis_tready`=0 and `data_count`=16 after the 16th push. Then set ready=1 → 0x0..0xF emerge in order, then `m_axis_tvalid`=0 and `data_count`=0.
- **Thresholds.** ALMOST_FULL_THRESH=14, ALMOST_EMPTY_THRESH=2 → `almost_full` rises on the push taking count 13→14. `almost_empty` falls on the push taking count 2→3.
- **Simultaneous push/pop.** Hold count at 8 with tvalid=tready=1 on both sides for 100 cycles → count stays 8 and no beat is lost or reordered.
- **Packet mode, short packet.** PACKET_MODE=1; push a 5-beat packet, tlast on beat 5, with one idle cycle between beats → `m_axis_tvalid`=0 until the cycle after beat 5. The drain yields 5 beats, tkeep intact, tlast on the 5th.
- **Packet mode, oversize packet.** PACKET_MODE=1; push a 40-beat packet with ready toggling randomly → `tvalid` asserts at full, all 40 beats emerge in order, tlast on beat 40.
- **Reset mid-operation, plus random soak.** Assert `rst` for one cycle with count=7 → next cycle count=0, `m_axis_tvalid`=0, `almost_empty`=1. Then run 1000 cycles of random valid/ready/data against a scoreboard → zero mismatches.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared constants and helpers for the single-clock AXI-Stream FIFO.
package axis_fifo_pkg;

  localparam int DEF_FIFO_DEPTH          = 16;
  localparam int DEF_FIFO_WIDTH          = 32;
  localparam int DEF_PACKET_MODE         = 0;
  localparam int DEF_ALMOST_EMPTY_THRESH = 2;

  // Pointers carry one extra wrap bit beyond the index.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int depth, input int width,
                                   input int af, input int ae);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (width > 0) && (width % 8 == 0) &&
           (af >= 0) && (af <= depth) && (ae >= 0) && (ae <= depth);
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous (fall-through) read.
module axis_fifo_mem
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_FIFO_WIDTH + DEF_FIFO_WIDTH / 8 + 1,
  localparam int AW   = ptr_w(DEPTH) - 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with optional store-and-forward packet mode,
// occupancy count and almost-full/almost-empty flags.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH          = DEF_FIFO_DEPTH,
  parameter int FIFO_WIDTH          = DEF_FIFO_WIDTH,
  parameter int PACKET_MODE         = DEF_PACKET_MODE,
  parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = DEF_ALMOST_EMPTY_THRESH,
  localparam int PW = ptr_w(FIFO_DEPTH),
  localparam int AW = PW - 1,
  localparam int KW = FIFO_WIDTH / 8,
  localparam int EW = FIFO_WIDTH + KW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] s_axis_tdata,
  input  logic [KW-1:0]         s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [FIFO_WIDTH-1:0] m_axis_tdata,
  output logic [KW-1:0]         m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [PW-1:0]         data_count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  if (!params_ok(FIFO_DEPTH, FIFO_WIDTH, ALMOST_FULL_THRESH, ALMOST_EMPTY_THRESH)) begin : g_bad_params
    $error("axis_sync_fifo: illegal parameter combination");
  end

  logic [PW-1:0] wr_ptr, rd_ptr, pkt_count;
  logic          draining;
  logic          full, empty, push, pop, pkt_ready;
  logic [EW-1:0] rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // full releases oversize packets; draining keeps a started packet flowing.
  assign pkt_ready     = (pkt_count != '0) || full || draining;
  assign m_axis_tvalid = !empty && ((PACKET_MODE == 0) || pkt_ready);
  assign s_axis_tready = !full;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      draining  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if ((push && s_axis_tlast) && !(pop && m_axis_tlast))
        pkt_count <= pkt_count + 1'b1;
      else if (!(push && s_axis_tlast) && (pop && m_axis_tlast))
        pkt_count <= pkt_count - 1'b1;
      if (pop) draining <= !m_axis_tlast;
    end
  end

  axis_fifo_mem #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_entry;

  assign data_count   = wr_ptr - rd_ptr;
  assign almost_full  = (data_count >= PW'(ALMOST_FULL_THRESH));
  assign almost_empty = (data_count <= PW'(ALMOST_EMPTY_THRESH));

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench: instance 0 streaming mode, instance 1 packet mode.
module tb_axis_sync_fifo;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk, rst;
  logic [31:0] s_data [2];
  logic [3:0]  s_keep [2];
  logic        s_last [2], s_vld [2], s_rdy [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_keep [2];
  logic        m_last [2], m_vld [2], m_rdy [2];
  logic [4:0]  cnt [2];
  logic        af [2], ae [2];

  beat_t q0[$], q1[$];
  int    total = 0, bad = 0;
  bit    tog_done = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  axis_sync_fifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(32), .PACKET_MODE(0),
                   .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data[0]), .s_axis_tkeep(s_keep[0]), .s_axis_tlast(s_last[0]),
    .s_axis_tvalid(s_vld[0]), .s_axis_tready(s_rdy[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tkeep(m_keep[0]), .m_axis_tlast(m_last[0]),
    .m_axis_tvalid(m_vld[0]), .m_axis_tready(m_rdy[0]),
    .data_count(cnt[0]), .almost_full(af[0]), .almost_empty(ae[0]));

  axis_sync_fifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(32), .PACKET_MODE(1),
                   .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data[1]), .s_axis_tkeep(s_keep[1]), .s_axis_tlast(s_last[1]),
    .s_axis_tvalid(s_vld[1]), .s_axis_tready(s_rdy[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tkeep(m_keep[1]), .m_axis_tlast(m_last[1]),
    .m_axis_tvalid(m_vld[1]), .m_axis_tready(m_rdy[1]),
    .data_count(cnt[1]), .almost_full(af[1]), .almost_empty(ae[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: every beat the DUT hands over must match the scoreboard head.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst && m_vld[u] && m_rdy[u]) begin
        beat_t e;
        if (qsize(u) == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected u=%0d: got %0h, expected no beat", u, m_data[u]);
        end else begin
          if (u == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("pop_u%0d", u), 64'({m_last[u], m_keep[u], m_data[u]}),
              64'({e.l, e.k, e.d}));
        end
      end
    end
  end

  task automatic push(input int u, input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok = 0;
    s_data[u] = d; s_keep[u] = k; s_last[u] = l; s_vld[u] = 1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_rdy[u]) begin
        if (u == 0) q0.push_back('{d, k, l}); else q1.push_back('{d, k, l});
        ok = 1;
      end
      @(posedge clk); #1;
    end
    s_vld[u] = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL push_timeout u=%0d data=%0h: got no ready, expected ready", u, d);
    end
  endtask

  task automatic drain(input int u, input string name);
    for (int t = 0; t < 300; t++) begin
      if (qsize(u) == 0 && !m_vld[u]) break;
      cyc();
    end
    chk({name, "_qempty"}, 64'(qsize(u)), 64'd0);
    chk({name, "_vld"}, 64'(m_vld[u]), 64'd0);
    chk({name, "_cnt"}, 64'(cnt[u]), 64'd0);
  endtask

  initial begin
    logic [3:0] keeps [5];
    keeps[0] = 4'h1; keeps[1] = 4'h3; keeps[2] = 4'h7; keeps[3] = 4'hF; keeps[4] = 4'h5;
    rst = 1;
    for (int u = 0; u < 2; u++) begin
      s_data[u] = '0; s_keep[u] = '0; s_last[u] = 0; s_vld[u] = 0; m_rdy[u] = 0;
    end
    cyc(); cyc();
    rst = 0;

    // Reset values
    chk("rst_tready", 64'(s_rdy[0]), 64'd1);
    chk("rst_tvalid", 64'(m_vld[0]), 64'd0);
    chk("rst_count", 64'(cnt[0]), 64'd0);
    chk("rst_af", 64'(af[0]), 64'd0);
    chk("rst_ae", 64'(ae[0]), 64'd1);
    chk("rst_tvalid_pkt", 64'(m_vld[1]), 64'd0);

    // Fill then drain, with flag thresholds checked along the way
    for (int i = 0; i < 16; i++) begin
      push(0, 32'(i), 4'(i), i == 15);
      chk($sformatf("fill_cnt%0d", i), 64'(cnt[0]), 64'(i + 1));
      chk($sformatf("fill_af%0d", i), 64'(af[0]), 64'((i + 1) >= 14));
      chk($sformatf("fill_ae%0d", i), 64'(ae[0]), 64'((i + 1) <= 2));
    end
    chk("full_tready", 64'(s_rdy[0]), 64'd0);
    chk("full_count", 64'(cnt[0]), 64'd16);
    s_data[0] = 32'hDEAD; s_vld[0] = 1;
    cyc(); cyc(); cyc();
    s_vld[0] = 0;
    chk("full_no_push", 64'(cnt[0]), 64'd16);
    m_rdy[0] = 1;
    drain(0, "fill_drain");

    // Simultaneous push and pop at count 8
    m_rdy[0] = 0;
    for (int i = 0; i < 8; i++) push(0, 32'h200 + 32'(i), 4'hF, 0);
    chk("sim_start_cnt", 64'(cnt[0]), 64'd8);
    m_rdy[0] = 1; s_vld[0] = 1; s_keep[0] = 4'hA; s_last[0] = 0;
    for (int k = 0; k < 100; k++) begin
      s_data[0] = 32'h100 + 32'(k);
      @(negedge clk);
      if (s_vld[0] && s_rdy[0]) q0.push_back('{s_data[0], s_keep[0], s_last[0]});
      cyc();
      if (k % 10 == 9) chk($sformatf("sim_cnt%0d", k), 64'(cnt[0]), 64'd8);
    end
    s_vld[0] = 0;
    drain(0, "sim_drain");

    // Packet mode, short packet with idle gaps
    m_rdy[1] = 1;
    for (int i = 0; i < 5; i++) begin
      push(1, 32'hA0 + 32'(i), keeps[i], i == 4);
      chk($sformatf("pkt_vld%0d", i), 64'(m_vld[1]), 64'(i == 4));
      if (i < 4) begin
        cyc();
        chk($sformatf("pkt_gap%0d", i), 64'(m_vld[1]), 64'd0);
      end
    end
    drain(1, "pkt_drain");

    // Packet mode, 40-beat packet with random ready
    tog_done = 0;
    fork
      while (!tog_done) begin
        @(posedge clk); #1;
        if (!tog_done) m_rdy[1] = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      push(1, 32'h5000 + 32'(i), 4'(i), i == 39);
      if (i < 16) chk($sformatf("big_vld%0d", i), 64'(m_vld[1]), 64'(i == 15));
    end
    tog_done = 1;
    m_rdy[1] = 1;
    drain(1, "big_drain");

    // Reset with 7 entries stored; inputs during reset are ignored
    m_rdy[0] = 0;
    for (int i = 0; i < 7; i++) push(0, 32'h700 + 32'(i), 4'h3, 0);
    chk("mid_cnt7", 64'(cnt[0]), 64'd7);
    rst = 1; s_vld[0] = 1; s_data[0] = 32'hBAD;
    q0.delete();
    cyc();
    rst = 0; s_vld[0] = 0;
    chk("mid_rst_cnt", 64'(cnt[0]), 64'd0);
    chk("mid_rst_vld", 64'(m_vld[0]), 64'd0);
    chk("mid_rst_ae", 64'(ae[0]), 64'd1);
    chk("mid_rst_tready", 64'(s_rdy[0]), 64'd1);

    // Random soak: count and flags must track the scoreboard occupancy
    for (int k = 0; k < 1000; k++) begin
      s_vld[0]  = 1'($urandom_range(0, 1));
      s_data[0] = $urandom;
      s_keep[0] = 4'($urandom_range(0, 15));
      s_last[0] = 1'($urandom_range(0, 1));
      m_rdy[0]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_vld[0] && s_rdy[0]) q0.push_back('{s_data[0], s_keep[0], s_last[0]});
      cyc();
      chk("soak_cnt", 64'(cnt[0]), 64'(q0.size()));
      chk("soak_af", 64'(af[0]), 64'(q0.size() >= 14));
      chk("soak_ae", 64'(ae[0]), 64'(q0.size() <= 2));
    end
    s_vld[0] = 0; m_rdy[0] = 1;
    drain(0, "soak_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
